// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data BRAM port arbiter.
// Performance counters are enabled by defining MEM_ARB_PERF_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } rsp_owner_e;

   localparam logic [3:0] WE_LOAD = 4'b0000;
   localparam logic [3:0] WE_B    = 4'b0001;
   localparam logic [3:0] WE_H    = 4'b0011;
   localparam logic [3:0] WE_W    = 4'b1111;

   // Only the three legal store encodings count as writes; anything else is a load.
   function automatic logic is_store_we(input logic [3:0] we);
      return (we == WE_B) || (we == WE_H) || (we == WE_W);
   endfunction

endpackage

// File: rtl/mem_wr_align.sv
// Shifts right-justified byte/half/word store data onto BRAM byte lanes and
// flags half/word stores that do not sit on their natural boundary.
module mem_wr_align
   import mem_arb_pkg::*;
(
   input  logic [3:0]  we_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  off_i,
   output logic [3:0]  mem_we_o,
   output logic [31:0] mem_wdata_o,
   output logic        misalign_o
);

   always_comb begin
      mem_wdata_o = wdata_i << {off_i, 3'b000};
      mem_we_o    = WE_LOAD;
      misalign_o  = 1'b0;
      case (we_i)
         WE_B: mem_we_o = WE_B << off_i;
         WE_H: begin
            if (off_i[0]) misalign_o = 1'b1;
            else          mem_we_o   = WE_H << off_i;
         end
         WE_W: begin
            if (off_i != 2'b00) misalign_o = 1'b1;
            else                mem_we_o   = WE_W;
         end
         default: mem_we_o = WE_LOAD;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port BRAM between fetch and data ports; data wins
// unless fetch has starved STARVE_LIM cycles. Stall counters need MEM_ARB_PERF_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int STARVE_LIM = 4,
   parameter int PERF_W     = 32
) (
   input  logic                               CPU_CLK,
   input  logic                               CPU_RST_N,
   input  logic                               IfReq,
   input  logic [ADDR_W-1:0]                  IfAddr,
   output logic                               IfGnt,
   output logic                               IfValid,
   output logic [31:0]                        IfRdata,
   input  logic                               DmReq,
   input  logic [ADDR_W-1:0]                  DmAddr,
   input  logic [3:0]                         DmWe,
   input  logic [31:0]                        DmWdata,
   output logic                               DmGnt,
   output logic                               DmValid,
   output logic [31:0]                        DmRdata,
   output logic                               DmMisalign,
   output logic                               MemEn,
   output logic [3:0]                         MemWe,
   output logic [ADDR_W-3:0]                  MemAddr,
   output logic [31:0]                        MemWdata,
   input  logic [31:0]                        MemRdata,
   output logic [PERF_W-1:0]                  PerfIfStall,
   output logic [PERF_W-1:0]                  PerfDmStall,
   output logic [1:0]                         DbgRspOwner,
   output logic [$clog2(STARVE_LIM+1)-1:0]    DbgStarveCnt
);

   localparam int SC_W = $clog2(STARVE_LIM + 1);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);

   // Handshake: a request is held with stable payload until its Gnt is seen
   // high in some cycle; the response (Valid) follows exactly one cycle later.

   rsp_owner_e      owner_q, owner_d;
   logic            rsp_write_q, rsp_write_d;
   logic            misalign_q, misalign_d;
   logic [SC_W-1:0] starve_q, starve_d;

   logic        dm_gnt, if_gnt;
   logic [3:0]  align_we;
   logic [31:0] align_wdata;
   logic        align_misalign;
   logic        unused_if_lsb;

   assign unused_if_lsb = ^IfAddr[1:0];

   assign dm_gnt = DmReq & ~(IfReq & (starve_q == STARVE_MAX));
   assign if_gnt = IfReq & ~dm_gnt;
   assign DmGnt  = dm_gnt;
   assign IfGnt  = if_gnt;

   mem_wr_align u_align (
      .we_i        (DmWe),
      .wdata_i     (DmWdata),
      .off_i       (DmAddr[1:0]),
      .mem_we_o    (align_we),
      .mem_wdata_o (align_wdata),
      .misalign_o  (align_misalign)
   );

   always_comb begin
      MemEn    = 1'b0;
      MemWe    = WE_LOAD;
      MemAddr  = '0;
      MemWdata = '0;
      if (dm_gnt) begin
         MemEn    = 1'b1;
         MemWe    = align_we;
         MemAddr  = DmAddr[ADDR_W-1:2];
         MemWdata = align_wdata;
      end else if (if_gnt) begin
         MemEn   = 1'b1;
         MemAddr = IfAddr[ADDR_W-1:2];
      end
   end

   always_comb begin
      owner_d     = OWN_NONE;
      rsp_write_d = 1'b0;
      misalign_d  = 1'b0;
      if (dm_gnt) begin
         owner_d     = OWN_DM;
         rsp_write_d = is_store_we(DmWe);
         misalign_d  = align_misalign;
      end else if (if_gnt) begin
         owner_d = OWN_IF;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!IfReq || if_gnt)          starve_d = '0;
      else if (starve_q < STARVE_MAX) starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
      if (!CPU_RST_N) begin
         owner_q     <= OWN_NONE;
         rsp_write_q <= 1'b0;
         misalign_q  <= 1'b0;
         starve_q    <= '0;
      end else begin
         owner_q     <= owner_d;
         rsp_write_q <= rsp_write_d;
         misalign_q  <= misalign_d;
         starve_q    <= starve_d;
      end
   end

   assign IfValid    = (owner_q == OWN_IF);
   assign IfRdata    = IfValid ? MemRdata : 32'h0;
   assign DmValid    = (owner_q == OWN_DM);
   assign DmRdata    = (DmValid && !rsp_write_q) ? MemRdata : 32'h0;
   assign DmMisalign = DmValid & misalign_q;

   assign DbgRspOwner  = owner_q;
   assign DbgStarveCnt = starve_q;

`ifdef MEM_ARB_PERF_EN
   logic [PERF_W-1:0] perf_if_q, perf_if_d;
   logic [PERF_W-1:0] perf_dm_q, perf_dm_d;

   // Saturate rather than wrap so a long run never reports a small count.
   always_comb begin
      perf_if_d = perf_if_q;
      perf_dm_d = perf_dm_q;
      if (IfReq && !if_gnt && (perf_if_q != '1)) perf_if_d = perf_if_q + 1'b1;
      if (DmReq && !dm_gnt && (perf_dm_q != '1)) perf_dm_d = perf_dm_q + 1'b1;
   end

   always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
      if (!CPU_RST_N) begin
         perf_if_q <= '0;
         perf_dm_q <= '0;
      end else begin
         perf_if_q <= perf_if_d;
         perf_dm_q <= perf_dm_d;
      end
   end

   assign PerfIfStall = perf_if_q;
   assign PerfDmStall = perf_dm_q;
`else
   assign PerfIfStall = '0;
   assign PerfDmStall = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency BRAM.
// Stall-counter checks follow MEM_ARB_PERF_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req;
  logic [15:0] if_addr, dm_addr;
  logic [3:0]  dm_we;
  logic [31:0] dm_wdata;
  logic        if_gnt, if_valid, dm_gnt, dm_valid, dm_misalign;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] perf_if, perf_dm;
  logic [1:0]  dbg_owner;
  logic [2:0]  dbg_starve;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:16383];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .STARVE_LIM(4), .PERF_W(32)) dut (
    .CPU_CLK(clk), .CPU_RST_N(rst_n),
    .IfReq(if_req), .IfAddr(if_addr), .IfGnt(if_gnt), .IfValid(if_valid), .IfRdata(if_rdata),
    .DmReq(dm_req), .DmAddr(dm_addr), .DmWe(dm_we), .DmWdata(dm_wdata),
    .DmGnt(dm_gnt), .DmValid(dm_valid), .DmRdata(dm_rdata), .DmMisalign(dm_misalign),
    .MemEn(mem_en), .MemWe(mem_we), .MemAddr(mem_addr), .MemWdata(mem_wdata),
    .MemRdata(mem_rdata), .PerfIfStall(perf_if), .PerfDmStall(perf_dm),
    .DbgRspOwner(dbg_owner), .DbgStarveCnt(dbg_starve)
  );

  // Read-first BRAM model with byte write enables.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic set_idle();
    if_req = 1'b0; dm_req = 1'b0; if_addr = '0; dm_addr = '0; dm_we = '0; dm_wdata = '0;
  endtask

  // Present one data request right after a falling edge; comb outputs settle by #1.
  task automatic dm_drive(input logic [15:0] addr, input logic [3:0] we, input logic [31:0] wd);
    @(negedge clk);
    dm_req = 1'b1; dm_addr = addr; dm_we = we; dm_wdata = wd;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid); end
    checks++; if (dm_valid !== 1'b0) begin failures++; $display("FAIL reset_dm_valid got=%0b exp=0", dm_valid); end
    checks++; if (dm_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%0b exp=0", dm_misalign); end
    checks++; if (dbg_owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", dbg_owner); end
    checks++; if (dbg_starve !== 3'd0) begin failures++; $display("FAIL reset_starve got=%0d exp=0", dbg_starve); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0b exp=0", mem_en); end
    checks++; if (perf_if !== 32'd0) begin failures++; $display("FAIL reset_perf_if got=%0d exp=0", perf_if); end
    rst_n = 1'b1;
  endtask

  task automatic test_if_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0040;
    #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL fetch_gnt got=%0b exp=1", if_gnt); end
    checks++; if (dm_gnt !== 1'b0) begin failures++; $display("FAIL fetch_dm_gnt got=%0b exp=0", dm_gnt); end
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL fetch_mem_en got=%0b exp=1", mem_en); end
    checks++; if (mem_addr !== 14'h0010) begin failures++; $display("FAIL fetch_mem_addr got=%h exp=0010", mem_addr); end
    checks++; if (mem_we !== 4'b0000) begin failures++; $display("FAIL fetch_mem_we got=%b exp=0000", mem_we); end
    @(negedge clk);
    set_idle();
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL fetch_valid got=%0b exp=1", if_valid); end
    checks++; if (if_rdata !== 32'h00500093) begin failures++; $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata); end
    checks++; if (dm_valid !== 1'b0) begin failures++; $display("FAIL fetch_dm_valid got=%0b exp=0", dm_valid); end
    #1;
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL idle_mem_en got=%0b exp=0", mem_en); end
  endtask

  // Both ports request for 6 cycles: data wins 4 times, fetch once, then data again.
  task automatic test_starvation();
    logic [5:0] exp_dm;
    exp_dm = 6'b101111;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_addr = 16'h0100; dm_we = 4'b0000; dm_wdata = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (dm_gnt !== exp_dm[c]) begin failures++; $display("FAIL starve_dm_gnt c=%0d got=%0b exp=%0b", c, dm_gnt, exp_dm[c]); end
      checks++; if (if_gnt !== !exp_dm[c]) begin failures++; $display("FAIL starve_if_gnt c=%0d got=%0b exp=%0b", c, if_gnt, !exp_dm[c]); end
      checks++; if (mem_addr !== (exp_dm[c] ? 14'h0040 : 14'h0010)) begin failures++; $display("FAIL starve_mem_addr c=%0d got=%h", c, mem_addr); end
      @(negedge clk);
      checks++; if (dm_valid !== exp_dm[c]) begin failures++; $display("FAIL starve_dm_valid c=%0d got=%0b exp=%0b", c, dm_valid, exp_dm[c]); end
      checks++; if (if_valid !== !exp_dm[c]) begin failures++; $display("FAIL starve_if_valid c=%0d got=%0b exp=%0b", c, if_valid, !exp_dm[c]); end
      if (exp_dm[c]) begin
        checks++; if (dm_rdata !== 32'h11223344) begin failures++; $display("FAIL starve_dm_rdata c=%0d got=%h exp=11223344", c, dm_rdata); end
      end else begin
        checks++; if (if_rdata !== 32'h00500093) begin failures++; $display("FAIL starve_if_rdata c=%0d got=%h exp=00500093", c, if_rdata); end
      end
    end
    set_idle();
  endtask

  task automatic test_store_byte();
    dm_drive(16'h0203, 4'b0001, 32'h000000AB);
    checks++; if (mem_we !== 4'b1000) begin failures++; $display("FAIL sb_mem_we got=%b exp=1000", mem_we); end
    checks++; if (mem_wdata !== 32'hAB000000) begin failures++; $display("FAIL sb_mem_wdata got=%h exp=AB000000", mem_wdata); end
    checks++; if (mem_addr !== 14'h0080) begin failures++; $display("FAIL sb_mem_addr got=%h exp=0080", mem_addr); end
    @(negedge clk);
    set_idle();
    checks++; if (dm_valid !== 1'b1) begin failures++; $display("FAIL sb_valid got=%0b exp=1", dm_valid); end
    checks++; if (dm_rdata !== 32'h0) begin failures++; $display("FAIL sb_rdata got=%h exp=0", dm_rdata); end
    checks++; if (dm_misalign !== 1'b0) begin failures++; $display("FAIL sb_misalign got=%0b exp=0", dm_misalign); end
    checks++; if (mem[14'h0080] !== 32'hAB667788) begin failures++; $display("FAIL sb_mem_word got=%h exp=AB667788", mem[14'h0080]); end
  endtask

  task automatic test_store_half();
    dm_drive(16'h0206, 4'b0011, 32'h00001234);
    checks++; if (mem_we !== 4'b1100) begin failures++; $display("FAIL sh_mem_we got=%b exp=1100", mem_we); end
    checks++; if (mem_wdata !== 32'h12340000) begin failures++; $display("FAIL sh_mem_wdata got=%h exp=12340000", mem_wdata); end
    dm_drive(16'h0201, 4'b0011, 32'h00005678);
    checks++; if (mem_we !== 4'b0000) begin failures++; $display("FAIL sh_mis_mem_we got=%b exp=0000", mem_we); end
    checks++; if (dm_misalign !== 1'b0) begin failures++; $display("FAIL sh_prev_misalign got=%0b exp=0", dm_misalign); end
    @(negedge clk);
    set_idle();
    checks++; if (dm_misalign !== 1'b1) begin failures++; $display("FAIL sh_mis_flag got=%0b exp=1", dm_misalign); end
    checks++; if (mem[14'h0081] !== 32'h1234BBCC) begin failures++; $display("FAIL sh_mem_word got=%h exp=1234BBCC", mem[14'h0081]); end
    checks++; if (mem[14'h0080] !== 32'hAB667788) begin failures++; $display("FAIL sh_mis_word got=%h exp=AB667788", mem[14'h0080]); end
  endtask

  task automatic test_misalign_word();
    dm_drive(16'h0202, 4'b1111, 32'hDEADBEEF);
    checks++; if (mem_we !== 4'b0000) begin failures++; $display("FAIL sw_mis_mem_we got=%b exp=0000", mem_we); end
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL sw_mis_mem_en got=%0b exp=1", mem_en); end
    @(negedge clk);
    set_idle();
    checks++; if (dm_valid !== 1'b1) begin failures++; $display("FAIL sw_mis_valid got=%0b exp=1", dm_valid); end
    checks++; if (dm_misalign !== 1'b1) begin failures++; $display("FAIL sw_mis_flag got=%0b exp=1", dm_misalign); end
    checks++; if (mem[14'h0080] !== 32'hAB667788) begin failures++; $display("FAIL sw_mis_word got=%h exp=AB667788", mem[14'h0080]); end
    @(negedge clk);
    checks++; if (dm_misalign !== 1'b0) begin failures++; $display("FAIL sw_mis_pulse got=%0b exp=0", dm_misalign); end
    dm_drive(16'h0200, 4'b1111, 32'hCAFEF00D);
    checks++; if (mem_we !== 4'b1111) begin failures++; $display("FAIL sw_mem_we got=%b exp=1111", mem_we); end
    @(negedge clk);
    set_idle();
    checks++; if (mem[14'h0080] !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_mem_word got=%h exp=CAFEF00D", mem[14'h0080]); end
  endtask

  task automatic test_bad_we();
    dm_drive(16'h0204, 4'b0101, 32'hFFFFFFFF);
    checks++; if (mem_we !== 4'b0000) begin failures++; $display("FAIL badwe_mem_we got=%b exp=0000", mem_we); end
    @(negedge clk);
    set_idle();
    checks++; if (dm_rdata !== 32'h1234BBCC) begin failures++; $display("FAIL badwe_rdata got=%h exp=1234BBCC", dm_rdata); end
    checks++; if (dm_misalign !== 1'b0) begin failures++; $display("FAIL badwe_misalign got=%0b exp=0", dm_misalign); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0040;
    #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_gnt got=%0b exp=1", if_gnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b0; set_idle();
    #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid_low got=%0b exp=0", if_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid_after got=%0b exp=0", if_valid); end
    checks++; if (dbg_owner !== 2'd0) begin failures++; $display("FAIL rstmid_owner got=%0d exp=0", dbg_owner); end
    checks++; if (dbg_starve !== 3'd0) begin failures++; $display("FAIL rstmid_starve got=%0d exp=0", dbg_starve); end
  endtask

  task automatic test_perf();
    logic [31:0] exp_if;
`ifdef MEM_ARB_PERF_EN
    exp_if = 32'd3;
`else
    exp_if = 32'd0;
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_addr = 16'h0100; dm_we = 4'b0000;
    repeat (3) @(negedge clk);
    set_idle();
    @(negedge clk);
    checks++; if (perf_if !== exp_if) begin failures++; $display("FAIL perf_if got=%0d exp=%0d", perf_if, exp_if); end
    checks++; if (perf_dm !== 32'd0) begin failures++; $display("FAIL perf_dm got=%0d exp=0", perf_dm); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[14'h0010] = 32'h00500093;
    mem[14'h0040] = 32'h11223344;
    mem[14'h0080] = 32'h55667788;
    mem[14'h0081] = 32'h99AABBCC;
    mem_rdata = 32'h0;
    test_reset();
    test_if_fetch();
    test_starvation();
    test_store_byte();
    test_store_half();
    test_misalign_word();
    test_bad_we();
    test_reset_mid();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
